// File: rtl/ram16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram16_pkg
//  Purpose  : Shared widths, FSM state encoding and address helper for the
//             RAM sequencing controller.
//  Revision : 1.0  initial release
// ============================================================================
package ram16_pkg;

    localparam int ADR_W  = 6;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Next burst address; the natural 6-bit overflow gives the 63 -> 0 wrap.
    function automatic logic [ADR_W-1:0] adr_next(input logic [ADR_W-1:0] a);
        return a + ADR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram16_beat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : ram16_beat_cnt
//  Purpose  : Loadable down-counter with zero flag; used both for the burst
//             beat count and for the HOLD/RDWAIT delay count.
//  Revision : 1.0  initial release
// ============================================================================
module ram16_beat_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero so a stray dec is harmless.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ram16_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram16_seq_ctrl
//  Purpose  : Burst sequencer for an asynchronous 64x8 RAM. Accepts one
//             read or fill request at a time and generates CE/WE/ADR/DIN
//             with setup, strobe and hold phases; read beats are returned
//             through a valid/ready response port.
//  Revision : 1.0  initial release
// ============================================================================
module ram16_seq_ctrl
    import ram16_pkg::*;
#(
    parameter int HOLD_CYC = 1,
    parameter int DLY_CYC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADR_W-1:0]  i_req_adr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic [DATA_W-1:0] i_req_data,
    output logic [ADR_W-1:0]  o_adr,
    output logic [DATA_W-1:0] o_din,
    output logic              o_we,
    output logic              o_ce,
    input  logic [DATA_W-1:0] i_dout,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data
);

    // Delay counter preloads: counter reaches zero in the last cycle of the phase.
    localparam logic [CNT_W-1:0] C_HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_DLY_LD  = CNT_W'(DLY_CYC - 1);

    state_t              r_state;
    logic                r_wr;
    logic [ADR_W-1:0]    r_adr;
    logic [DATA_W-1:0]   r_din;
    logic                r_we;
    logic                r_ce;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_accept;
    logic                w_beat_dec;
    logic                w_beat_zero;
    logic                w_dly_load;
    logic [CNT_W-1:0]    w_dly_val;
    logic                w_dly_dec;
    logic                w_dly_zero;

    // Counter control derived from the current state.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && i_req_valid && r_req_ready;
        w_dly_load = (r_state == ST_STROBE) || ((r_state == ST_SETUP) && !r_wr);
        w_dly_val  = (r_state == ST_STROBE) ? C_HOLD_LD : C_DLY_LD;
        w_dly_dec  = (r_state == ST_HOLD) || (r_state == ST_RDWAIT);
        w_beat_dec = ((r_state == ST_HOLD) && w_dly_zero) ||
                     ((r_state == ST_RESP) && i_rsp_ready);
    end

    ram16_beat_cnt #(.W(LEN_W)) u_beat_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_accept),
        .i_load_val (i_req_len),
        .i_dec      (w_beat_dec),
        .o_zero     (w_beat_zero)
    );

    ram16_beat_cnt #(.W(CNT_W)) u_dly_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_val),
        .i_dec      (w_dly_dec),
        .o_zero     (w_dly_zero)
    );

    // Sequencer FSM; every RAM-facing and handshake output is registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_wr        <= 1'b0;
            r_adr       <= '0;
            r_din       <= '0;
            r_we        <= 1'b0;
            r_ce        <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_we        <= 1'b0;
                    r_ce        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_wr        <= i_req_wr;
                        r_adr       <= i_req_adr;
                        r_din       <= i_req_data;
                        r_ce        <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_wr) begin
                        r_we    <= 1'b1;
                        r_state <= ST_STROBE;
                    end else begin
                        r_state <= ST_RDWAIT;
                    end
                end
                ST_STROBE: begin
                    r_we    <= 1'b0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_dly_zero) begin
                        if (w_beat_zero) begin
                            r_ce        <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_adr   <= adr_next(r_adr);
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (w_dly_zero) begin
                        r_rsp_data  <= i_dout;
                        r_rsp_valid <= 1'b1;
                        r_ce        <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_beat_zero) begin
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_ce    <= 1'b1;
                            r_adr   <= adr_next(r_adr);
                            r_state <= ST_SETUP;
                        end
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_ce    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_adr       = r_adr;
    assign o_din       = r_din;
    assign o_we        = r_we;
    assign o_ce        = r_ce;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_ram16_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram16_seq_ctrl
//  Purpose  : Self-checking bench for ram16_seq_ctrl with a 64x8 RAM model
//             and a memory-image reference model of request effects.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram16_seq_ctrl;

    localparam int HOLD_CYC = 1;
    localparam int DLY_CYC  = 2;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic       i_req_wr = 1'b0;
    logic [5:0] i_req_adr = '0;
    logic [5:0] i_req_len = '0;
    logic [7:0] i_req_data = '0;
    logic [5:0] o_adr;
    logic [7:0] o_din;
    logic       o_we;
    logic       o_ce;
    logic [7:0] i_dout;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b0;
    logic [7:0] o_rsp_data;

    always #5 clk = ~clk;

    ram16_seq_ctrl #(.HOLD_CYC(HOLD_CYC), .DLY_CYC(DLY_CYC)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wr    (i_req_wr),
        .i_req_adr   (i_req_adr),
        .i_req_len   (i_req_len),
        .i_req_data  (i_req_data),
        .o_adr       (o_adr),
        .o_din       (o_din),
        .o_we        (o_we),
        .o_ce        (o_ce),
        .i_dout      (i_dout),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data)
    );

    // RAM model: asynchronous read, write on a clock edge with CE and WE high.
    logic [7:0] mem [64];
    logic       preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i + 1);
        end else if (o_ce && o_we) begin
            mem[o_adr] <= o_din;
        end
    end
    assign i_dout = mem[o_adr];

    // Reference memory image, updated from request semantics only.
    logic [7:0] exp_mem [64];

    int n_pass = 0;
    int n_total = 0;
    int n_viol = 0;
    int cyc = 0;
    bit rst_at_edge = 1'b1;
    bit last_hs = 1'b0;
    bit op_wr = 1'b0;
    int acc_cyc_q[$];
    logic [13:0] wlog[$];
    logic [7:0]  rd_q[$];

    // Edge-time observations of handshakes and reset.
    always @(posedge clk) begin
        cyc++;
        rst_at_edge = !i_rst_n;
        last_hs = o_rsp_valid && i_rsp_ready && i_rst_n;
        if (i_req_valid && o_req_ready && i_rst_n) begin
            acc_cyc_q.push_back(cyc);
            op_wr = i_req_wr;
        end
    end

    // Protocol monitor: logs write pulses and counts rule violations.
    bit         prev_ok = 1'b0;
    logic [5:0] p_adr;
    logic [7:0] p_din;
    logic       p_rsp_valid;
    logic [7:0] p_rsp_data;
    always @(negedge clk) begin
        if (rst_at_edge) begin
            prev_ok = 1'b0;
        end else begin
            if (o_we) begin
                wlog.push_back({o_adr, o_din});
                if (!o_ce || !prev_ok || o_adr !== p_adr || o_din !== p_din) n_viol++;
            end
            if (o_req_ready && o_ce) n_viol++;
            if (o_rsp_valid && o_ce) n_viol++;
            if (o_rsp_valid && op_wr) n_viol++;
            if (prev_ok && p_rsp_valid && !last_hs &&
                (!o_rsp_valid || o_rsp_data !== p_rsp_data)) n_viol++;
            prev_ok = 1'b1;
        end
        p_adr = o_adr;
        p_din = o_din;
        p_rsp_valid = o_rsp_valid;
        p_rsp_data = o_rsp_data;
    end

    // Offer a request and return just after the edge that accepts it.
    task automatic do_req(input bit wr, input logic [5:0] adr, input logic [5:0] len,
                          input logic [7:0] data);
        int  t;
        bit  rdy;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_wr    = wr;
        i_req_adr   = adr;
        i_req_len   = len;
        i_req_data  = data;
        t = 0;
        forever begin
            rdy = o_req_ready;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 200) begin
                $display("FAIL req_accept_timeout: got no accept want accept within 200 cycles");
                n_total++;
                break;
            end
            @(negedge clk);
        end
        #1 i_req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_req_ready && t < 500);
        if (!o_req_ready) begin
            $display("FAIL ready_timeout: got req_ready=0 want 1 within 500 cycles");
            n_total++;
        end
    endtask

    // Collect n read beats with randomly stalled RSP_READY.
    task automatic collect_reads(input int n, input int stall_pct);
        int t;
        bit rdy;
        rd_q.delete();
        t = 0;
        while (rd_q.size() < n && t < 2000) begin
            @(negedge clk);
            rdy = ($urandom_range(99) >= stall_pct);
            i_rsp_ready = rdy;
            if (o_rsp_valid && rdy) rd_q.push_back(o_rsp_data);
            t++;
        end
        @(posedge clk);
        #1 i_rsp_ready = 1'b0;
        if (rd_q.size() != n) begin
            $display("FAIL read_collect: got %0d beats want %0d", rd_q.size(), n);
            n_total++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        if (o_req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", o_req_ready); else n_pass++;
        n_total++;
        if (o_ce !== 1'b0) $display("FAIL rst_ce: got %b want 0", o_ce); else n_pass++;
        n_total++;
        if (o_we !== 1'b0) $display("FAIL rst_we: got %b want 0", o_we); else n_pass++;
        n_total++;
        if (o_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", o_rsp_valid); else n_pass++;
        n_total++;
        if (o_adr !== 6'd0) $display("FAIL rst_adr: got %0d want 0", o_adr); else n_pass++;
        n_total++;
        if (o_din !== 8'd0) $display("FAIL rst_din: got %0h want 0", o_din); else n_pass++;
        n_total++;
        if (o_rsp_data !== 8'd0) $display("FAIL rst_rsp_data: got %0h want 0", o_rsp_data); else n_pass++;
        n_total++;
        i_rst_n = 1'b1;
        #1;
        if (o_req_ready !== 1'b0) $display("FAIL rst_ready_before_edge: got %b want 0", o_req_ready); else n_pass++;
        n_total++;
        @(negedge clk);
        if (o_req_ready !== 1'b1) $display("FAIL rst_ready_after_edge: got %b want 1", o_req_ready); else n_pass++;
        n_total++;
    endtask

    task automatic test_single_write();
        int ce_cnt, we_cnt, rdy_at;
        wlog.delete();
        do_req(1'b1, 6'd5, 6'd0, 8'hA5);
        exp_mem[5] = 8'hA5;
        ce_cnt = 0; we_cnt = 0; rdy_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (o_ce) ce_cnt++;
            if (o_we) we_cnt++;
            if (o_req_ready && rdy_at < 0) rdy_at = k;
        end
        if (ce_cnt != 2 + HOLD_CYC) $display("FAIL sw_ce_cycles: got %0d want %0d", ce_cnt, 2 + HOLD_CYC); else n_pass++;
        n_total++;
        if (we_cnt != 1) $display("FAIL sw_we_cycles: got %0d want 1", we_cnt); else n_pass++;
        n_total++;
        if (wlog.size() != 1 || wlog[0] !== {6'd5, 8'hA5})
            $display("FAIL sw_we_target: got %0d entries want 1 at adr 5 data a5", wlog.size());
        else n_pass++;
        n_total++;
        if (rdy_at != 3 + HOLD_CYC) $display("FAIL sw_ready_return: got %0d want %0d", rdy_at, 3 + HOLD_CYC); else n_pass++;
        n_total++;
        if (mem[5] !== exp_mem[5]) $display("FAIL sw_mem: got %0h want %0h", mem[5], exp_mem[5]); else n_pass++;
        n_total++;
    endtask

    task automatic test_fill_wrap();
        logic [5:0] a;
        wlog.delete();
        do_req(1'b1, 6'd62, 6'd3, 8'h3C);
        wait_ready();
        if (wlog.size() != 4) $display("FAIL fill_pulses: got %0d want 4", wlog.size()); else n_pass++;
        n_total++;
        for (int k = 0; k < 4; k++) begin
            a = 6'((62 + k) % 64);
            exp_mem[a] = 8'h3C;
            if (k < wlog.size()) begin
                if (wlog[k] !== {a, 8'h3C})
                    $display("FAIL fill_order: got %0h want %0h", wlog[k], {a, 8'h3C});
                else n_pass++;
                n_total++;
            end
        end
    endtask

    task automatic test_read();
        do_req(1'b0, 6'd10, 6'd1, 8'h00);
        collect_reads(2, 40);
        for (int k = 0; k < 2 && k < rd_q.size(); k++) begin
            if (rd_q[k] !== exp_mem[10 + k])
                $display("FAIL read_data: got %0h want %0h", rd_q[k], exp_mem[10 + k]);
            else n_pass++;
            n_total++;
        end
        wait_ready();
    endtask

    task automatic test_resp_stall();
        int         k;
        logic [5:0] adr0;
        logic [7:0] d0;
        i_rsp_ready = 1'b0;
        do_req(1'b0, 6'd30, 6'd1, 8'h00);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_rsp_valid && k < 30);
        if (k != 2 + DLY_CYC) $display("FAIL rd_latency: got %0d want %0d", k, 2 + DLY_CYC); else n_pass++;
        n_total++;
        adr0 = o_adr;
        d0 = o_rsp_data;
        if (d0 !== exp_mem[30]) $display("FAIL stall_first_data: got %0h want %0h", d0, exp_mem[30]); else n_pass++;
        n_total++;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", o_rsp_valid); else n_pass++;
            n_total++;
            if (o_rsp_data !== d0) $display("FAIL stall_data: got %0h want %0h", o_rsp_data, d0); else n_pass++;
            n_total++;
            if (o_ce !== 1'b0) $display("FAIL stall_ce: got %b want 0", o_ce); else n_pass++;
            n_total++;
            if (o_adr !== adr0) $display("FAIL stall_adr: got %0d want %0d", o_adr, adr0); else n_pass++;
            n_total++;
        end
        collect_reads(2, 0);
        if (rd_q.size() == 2) begin
            if (rd_q[1] !== exp_mem[31]) $display("FAIL stall_second_data: got %0h want %0h", rd_q[1], exp_mem[31]); else n_pass++;
            n_total++;
        end
        wait_ready();
    endtask

    task automatic test_reset_mid();
        int t;
        do_req(1'b1, 6'd20, 6'd3, 8'h5A);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_we && t < 20);
        if (!o_we) begin
            $display("FAIL midrst_strobe: got no WE want WE within 20 cycles");
            n_total++;
        end
        i_rst_n = 1'b0;
        exp_mem[20] = 8'h5A;
        @(negedge clk);
        if (o_we !== 1'b0 || o_ce !== 1'b0)
            $display("FAIL midrst_we_ce: got we=%b ce=%b want 0 0", o_we, o_ce);
        else n_pass++;
        n_total++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0)
            $display("FAIL midrst_outputs: got rsp_valid=%b ready=%b want 0 0", o_rsp_valid, o_req_ready);
        else n_pass++;
        n_total++;
        i_rst_n = 1'b1;
        @(negedge clk);
        if (o_req_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", o_req_ready); else n_pass++;
        n_total++;
        if (mem[20] !== exp_mem[20] || mem[21] !== exp_mem[21])
            $display("FAIL midrst_mem: got %0h %0h want %0h %0h", mem[20], mem[21], exp_mem[20], exp_mem[21]);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_back_to_back();
        int n0, t;
        n0 = acc_cyc_q.size();
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_wr = 1'b1; i_req_adr = 6'd40; i_req_len = 6'd1; i_req_data = 8'hC3;
        t = 0;
        while (acc_cyc_q.size() <= n0 && t < 100) begin @(negedge clk); t++; end
        i_req_wr = 1'b0; i_req_adr = 6'd40; i_req_len = 6'd1; i_req_data = 8'h00;
        exp_mem[40] = 8'hC3;
        exp_mem[41] = 8'hC3;
        t = 0;
        while (acc_cyc_q.size() <= n0 + 1 && t < 100) begin @(negedge clk); t++; end
        i_req_valid = 1'b0;
        if (acc_cyc_q.size() != n0 + 2) begin
            $display("FAIL b2b_accepts: got %0d want 2", acc_cyc_q.size() - n0);
            n_total++;
        end else begin
            if (acc_cyc_q[n0 + 1] - acc_cyc_q[n0] != 2 * (2 + HOLD_CYC) + 1)
                $display("FAIL b2b_gap: got %0d want %0d", acc_cyc_q[n0 + 1] - acc_cyc_q[n0], 2 * (2 + HOLD_CYC) + 1);
            else n_pass++;
            n_total++;
        end
        collect_reads(2, 30);
        for (int k = 0; k < rd_q.size(); k++) begin
            if (rd_q[k] !== exp_mem[40 + k]) $display("FAIL b2b_read: got %0h want %0h", rd_q[k], exp_mem[40 + k]); else n_pass++;
            n_total++;
        end
        wait_ready();
    endtask

    task automatic test_random();
        bit         wr;
        logic [5:0] adr, len, a;
        logic [7:0] data;
        for (int r = 0; r < 14; r++) begin
            wr   = 1'($urandom_range(1));
            adr  = 6'($urandom_range(63));
            len  = 6'($urandom_range(5));
            data = 8'($urandom_range(255));
            if (wr) begin
                wlog.delete();
                do_req(1'b1, adr, len, data);
                wait_ready();
                if (wlog.size() != int'(len) + 1) $display("FAIL rnd_wr_count: got %0d want %0d", wlog.size(), len + 1); else n_pass++;
                n_total++;
                for (int k = 0; k <= int'(len); k++) begin
                    a = 6'(adr + k);
                    exp_mem[a] = data;
                    if (k < wlog.size()) begin
                        if (wlog[k] !== {a, data}) $display("FAIL rnd_wr_beat: got %0h want %0h", wlog[k], {a, data}); else n_pass++;
                        n_total++;
                    end
                end
            end else begin
                do_req(1'b0, adr, len, 8'h00);
                collect_reads(int'(len) + 1, 35);
                for (int k = 0; k < rd_q.size(); k++) begin
                    a = 6'(adr + k);
                    if (rd_q[k] !== exp_mem[a]) $display("FAIL rnd_rd_beat: got %0h want %0h at adr %0d", rd_q[k], exp_mem[a], a); else n_pass++;
                    n_total++;
                end
                wait_ready();
            end
        end
    endtask

    task automatic test_invariants();
        if (n_viol != 0) $display("FAIL protocol_rules: got %0d violations want 0", n_viol); else n_pass++;
        n_total++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i + 1);
        test_reset();
        test_read();
        test_single_write();
        test_fill_wrap();
        test_resp_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
